mem_copy_master: RTL and testbench

//  Bus initiator for the SoC mem_cmd/mem_rsp interface: the opposite end from the RAM/GPIO/SBUF responders.

---
 rtl/mem_copy_master_pkg.sv | 32 +++
 rtl/mem_copy_master_if.sv | 45 ++++
 rtl/mem_copy_master.sv | 203 ++++++++++++++++++++
 tb/tb_mem_copy_master.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_master_pkg
// Brief    : Shared bus widths, FSM state encoding and helpers for the
//            mem_cmd/mem_rsp bus masters.
// Revision : 1.0
// ============================================================================
package mem_copy_master_pkg;

    localparam int c_ADDR_W  = 32;
    localparam int c_DATA_W  = 32;
    localparam int c_BE_W    = 4;
    localparam int c_STATE_W = 3;

    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_IDLE    = 3'd0;
    localparam state_t c_RD_CMD  = 3'd1;
    localparam state_t c_RD_WAIT = 3'd2;
    localparam state_t c_WR_CMD  = 3'd3;
    localparam state_t c_DONE    = 3'd4;

    localparam logic [c_ADDR_W-1:0] c_WORD_STRIDE = 32'd4;
    localparam logic [c_BE_W-1:0]   c_BE_ALL      = 4'hf;

    // Byte address to the word-aligned address the bus expects.
    function automatic logic [c_ADDR_W-1:0] word_align(input logic [c_ADDR_W-1:0] addr);
        return addr & ~c_ADDR_W'(3);
    endfunction

endpackage : mem_copy_master_pkg
`default_nettype wire

// File: rtl/mem_copy_master_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_master_if
// Brief    : SoC mem_cmd/mem_rsp bus bundle with initiator and responder views.
// Revision : 1.0
// ============================================================================
interface mem_copy_master_if;
    import mem_copy_master_pkg::*;

    logic                mem_cmd_valid;
    logic                mem_cmd_ready;
    logic                mem_cmd_wr;
    logic                mem_cmd_instr;
    logic [c_ADDR_W-1:0] mem_cmd_addr;
    logic [c_DATA_W-1:0] mem_cmd_wdata;
    logic [c_BE_W-1:0]   mem_cmd_be;
    logic                mem_rsp_ready;
    logic [c_DATA_W-1:0] mem_rsp_rdata;

    modport master (
        output mem_cmd_valid,
        input  mem_cmd_ready,
        output mem_cmd_wr,
        output mem_cmd_instr,
        output mem_cmd_addr,
        output mem_cmd_wdata,
        output mem_cmd_be,
        input  mem_rsp_ready,
        input  mem_rsp_rdata
    );

    modport slave (
        input  mem_cmd_valid,
        output mem_cmd_ready,
        input  mem_cmd_wr,
        input  mem_cmd_instr,
        input  mem_cmd_addr,
        input  mem_cmd_wdata,
        input  mem_cmd_be,
        output mem_rsp_ready,
        output mem_rsp_rdata
    );

endinterface : mem_copy_master_if
`default_nettype wire

// File: rtl/mem_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_master
// Brief    : Bus initiator copying len_words words from src to dst with
//            one outstanding read, optional read-response timeout.
// Revision : 1.0
// ============================================================================
module mem_copy_master
    import mem_copy_master_pkg::*;
#(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 start,
    input  wire [c_ADDR_W-1:0]  src_addr,
    input  wire [c_ADDR_W-1:0]  dst_addr,
    input  wire [LEN_W-1:0]     len_words,
    output logic                busy,
    output logic                done,
    output logic                error,
    mem_copy_master_if.master   mem
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [LEN_W-1:0]   c_LEN_ONE = LEN_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_ADDR_W-1:0] r_src;
    logic [c_ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]    r_len;
    logic [c_DATA_W-1:0] r_rdata;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_error;

    logic                w_cmd_valid;
    logic                w_cmd_wr;
    logic                w_busy;
    logic                w_done;
    logic                w_cmd_fire;
    logic                w_start_ok;
    logic                w_timeout;

    assign w_cmd_fire = w_cmd_valid && mem.mem_cmd_ready;
    assign w_start_ok = (r_state == c_IDLE) && start;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign w_timeout = (r_cnt == c_TIMEOUT);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = (len_words == '0) ? c_DONE : c_RD_CMD;
                end
            end
            c_RD_CMD: begin
                if (w_cmd_fire) begin
                    w_state_nxt = c_RD_WAIT;
                end
            end
            c_RD_WAIT: begin
                // A response arriving on the timeout cycle still wins.
                if (mem.mem_rsp_ready) begin
                    w_state_nxt = c_WR_CMD;
                end else if (w_timeout) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_WR_CMD: begin
                if (w_cmd_fire) begin
                    w_state_nxt = (r_len == c_LEN_ONE) ? c_DONE : c_RD_CMD;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, straight from the state flops)
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_valid = 1'b0;
        w_cmd_wr    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_RD_CMD: begin
                w_cmd_valid = 1'b1;
                w_busy      = 1'b1;
            end
            c_RD_WAIT: begin
                w_busy      = 1'b1;
            end
            c_WR_CMD: begin
                w_cmd_valid = 1'b1;
                w_cmd_wr    = 1'b1;
                w_busy      = 1'b1;
            end
            c_DONE: begin
                w_done      = 1'b1;
            end
            default: begin
                w_cmd_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: addresses, remaining count, read latch, timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start && (len_words != '0)) begin
                        r_src <= word_align(src_addr);
                        r_dst <= word_align(dst_addr);
                        r_len <= len_words;
                    end
                end
                c_RD_CMD: begin
                    if (w_cmd_fire) begin
                        r_src <= r_src + c_WORD_STRIDE;
                        r_cnt <= '0;
                    end
                end
                c_RD_WAIT: begin
                    if (mem.mem_rsp_ready) begin
                        r_rdata <= mem.mem_rsp_rdata;
                    end else if (!w_timeout) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_WR_CMD: begin
                    if (w_cmd_fire) begin
                        r_dst <= r_dst + c_WORD_STRIDE;
                        r_len <= r_len - c_LEN_ONE;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Sticky until the next accepted start, including a zero-length one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_start_ok) begin
            r_error <= 1'b0;
        end else if ((r_state == c_RD_WAIT) && !mem.mem_rsp_ready && w_timeout) begin
            r_error <= 1'b1;
        end
    end

    assign busy  = w_busy;
    assign done  = w_done;
    assign error = r_error;

    assign mem.mem_cmd_valid = w_cmd_valid;
    assign mem.mem_cmd_wr    = w_cmd_wr;
    assign mem.mem_cmd_instr = 1'b0;
    assign mem.mem_cmd_addr  = w_cmd_wr ? r_dst : r_src;
    assign mem.mem_cmd_wdata = r_rdata;
    assign mem.mem_cmd_be    = c_BE_ALL;

endmodule : mem_copy_master
`default_nettype wire

// File: tb/tb_mem_copy_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_copy_master
// Brief    : Scoreboard bench: bus responder model plus directed copy scenarios.
// Revision : 1.0
// ============================================================================
module tb_mem_copy_master;

    localparam int LEN_W = 16;
    localparam int TMO   = 8;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len_words;
    logic             busy;
    logic             done;
    logic             error;

    mem_copy_master_if bus ();

    mem_copy_master #(
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_acc   = 0;
    int   n_valid_seen = 0;
    int   n_done  = 0;
    int   last_rd_acc_cyc = 0;
    cmd_t exp_q[$];

    int   rd_lat      = 2;
    int   stall       = 0;
    bit   no_resp     = 1'b0;
    bit   hold_wr_low = 1'b0;
    bit   stray_req   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Bus responder: ready/stall policy, in-order read responses, scoreboard pop.
    initial begin : responder
        int          stall_cnt;
        int          pend;
        logic [31:0] pend_data;
        logic [31:0] snap_addr;
        logic [31:0] snap_wdata;
        bit          snap_wr;
        bit          in_stall;
        cmd_t        e;
        stall_cnt = 0;
        pend      = 0;
        pend_data = '0;
        in_stall  = 1'b0;
        bus.mem_cmd_ready = 1'b0;
        bus.mem_rsp_ready = 1'b0;
        bus.mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
                pend      = 0;
                in_stall  = 1'b0;
                bus.mem_cmd_ready = 1'b0;
                bus.mem_rsp_ready = 1'b0;
                continue;
            end
            if (done) n_done++;
            bus.mem_rsp_ready = 1'b0;
            if (stray_req) begin
                bus.mem_rsp_ready = 1'b1;
                bus.mem_rsp_rdata = 32'hBAD0_0BAD;
                stray_req = 1'b0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.mem_rsp_ready = 1'b1;
                    bus.mem_rsp_rdata = pend_data;
                end
            end
            if (bus.mem_cmd_valid) begin
                n_valid_seen++;
                if (in_stall) begin
                    check("hold_addr",  bus.mem_cmd_addr,  snap_addr);
                    check("hold_wr",    bus.mem_cmd_wr,    snap_wr);
                    check("hold_wdata", bus.mem_cmd_wdata, snap_wdata);
                end else begin
                    snap_addr  = bus.mem_cmd_addr;
                    snap_wr    = bus.mem_cmd_wr;
                    snap_wdata = bus.mem_cmd_wdata;
                    in_stall   = 1'b1;
                end
            end
            bus.mem_cmd_ready = !(hold_wr_low && bus.mem_cmd_wr) && (stall_cnt >= stall);
            if (bus.mem_cmd_valid && !bus.mem_cmd_ready) stall_cnt++;
            if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
                n_acc++;
                stall_cnt = 0;
                in_stall  = 1'b0;
                check("cmd_instr", bus.mem_cmd_instr, 0);
                check("cmd_be",    bus.mem_cmd_be, 4'hf);
                check("cmd_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("cmd_wr",   bus.mem_cmd_wr,   e.wr);
                    check("cmd_addr", bus.mem_cmd_addr, e.addr);
                    if (e.wr) begin
                        check("cmd_wdata", bus.mem_cmd_wdata, e.data);
                    end else begin
                        last_rd_acc_cyc = cyc;
                        if (!no_resp) begin
                            pend      = rd_lat;
                            pend_data = data_of(bus.mem_cmd_addr);
                        end
                    end
                end
            end
        end
    end

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int l);
        logic [31:0] a;
        for (int i = 0; i < l; i++) begin
            a = s + 32'(4 * i);
            exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0});
            exp_q.push_back('{wr: 1'b1, addr: d + 32'(4 * i), data: data_of(a)});
        end
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = l;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k;
        k = 0;
        while (!done && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, done, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a0;
        int d0;
        int v0;
        int diff;
        int k;
        reset     = 1'b1;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len_words = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.mem_cmd_valid, 0);
        check("rst_wr",    bus.mem_cmd_wr,    0);
        check("rst_addr",  bus.mem_cmd_addr,  0);
        check("rst_wdata", bus.mem_cmd_wdata, 0);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_error", error, 0);
        reset = 1'b0;

        // 1: basic copy, 2-cycle read latency
        rd_lat = 2; stall = 0;
        a0 = n_acc; d0 = n_done;
        push_copy(32'h100, 32'h200, 4);
        do_start(32'h100, 32'h200, 4);
        check("t1_busy", busy, 1);
        wait_done("t1_done", 200);
        check("t1_busy_at_done", busy, 0);
        check("t1_error", error, 0);
        repeat (3) @(negedge clk);
        check("t1_queue", exp_q.size(), 0);
        check("t1_accepts", n_acc - a0, 8);
        check("t1_done_count", n_done - d0, 1);

        // 2: zero length
        v0 = n_valid_seen; d0 = n_done;
        do_start(32'h100, 32'h200, 0);
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        @(negedge clk);
        check("t2_done_pulse", done, 0);
        check("t2_busy_after", busy, 0);
        repeat (3) @(negedge clk);
        check("t2_no_valid", n_valid_seen - v0, 0);
        check("t2_done_count", n_done - d0, 1);

        // 3: 5-cycle stall on every command
        rd_lat = 1; stall = 5;
        a0 = n_acc;
        push_copy(32'h400, 32'h800, 3);
        do_start(32'h400, 32'h800, 3);
        wait_done("t3_done", 400);
        check("t3_error", error, 0);
        @(negedge clk);
        check("t3_queue", exp_q.size(), 0);
        check("t3_accepts", n_acc - a0, 6);
        stall = 0;

        // 4: no read response -> timeout
        no_resp = 1'b1;
        exp_q.push_back('{wr: 1'b0, addr: 32'h1000, data: 32'h0});
        do_start(32'h1000, 32'h2000, 2);
        wait_done("t4_done", 100);
        diff = cyc - last_rd_acc_cyc;
        check("t4_error", error, 1);
        check("t4_tmo_window", (diff >= TMO + 1) && (diff <= TMO + 3), 1);
        @(negedge clk);
        check("t4_error_sticky", error, 1);
        check("t4_queue", exp_q.size(), 0);
        no_resp = 1'b0;
        push_copy(32'h3000, 32'h3100, 1);
        do_start(32'h3000, 32'h3100, 1);
        check("t4_error_cleared", error, 0);
        wait_done("t4_done2", 100);
        check("t4_error_after", error, 0);
        @(negedge clk);
        check("t4_queue2", exp_q.size(), 0);

        // 5: address wrap, ignored start mid-copy, stray response in idle
        rd_lat = 1;
        push_copy(32'hffff_fffc, 32'h500, 2);
        do_start(32'hffff_fffc, 32'h500, 2);
        check("t5_busy", busy, 1);
        do_start(32'h9000, 32'h9100, 5);
        wait_done("t5_done", 100);
        check("t5_error", error, 0);
        repeat (2) @(negedge clk);
        check("t5_queue", exp_q.size(), 0);
        v0 = n_valid_seen; d0 = n_done;
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_stray_busy", busy, 0);
        check("t5_stray_valid", n_valid_seen - v0, 0);
        check("t5_stray_done", n_done - d0, 0);

        // 6: reset while a write is stalled
        hold_wr_low = 1'b1;
        push_copy(32'h600, 32'h700, 1);
        do_start(32'h600, 32'h700, 1);
        k = 0;
        while (!(bus.mem_cmd_valid && bus.mem_cmd_wr) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_in_wr_cmd", bus.mem_cmd_valid & bus.mem_cmd_wr, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_valid_async", bus.mem_cmd_valid, 0);
        check("t6_busy_async", busy, 0);
        exp_q.delete();
        hold_wr_low = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("t6_error_rst", error, 0);
        push_copy(32'h640, 32'h740, 1);
        do_start(32'h640, 32'h740, 1);
        wait_done("t6_done", 100);
        check("t6_error", error, 0);
        @(negedge clk);
        check("t6_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_copy_master
`default_nettype wire
